// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM between port 0 (CPU) and port 1
// (loader / IO engine). Every access runs the fixed sequence
// IDLE -> ACCESS -> WAIT -> ACK; simultaneous requests are resolved round-robin.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// them stable until ackN; ackN is a single-cycle completion pulse, and for a
// read rdata is valid in the same cycle. Requests are sampled only in IDLE.
//
// Optional feature: define RAM_ARBITER_HALT_EN to drive halt high while
// port 1 owns the RAM (ACCESS through ACK). Otherwise halt is tied to 0.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              owner,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              halt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_oe_q, ram_oe_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant;

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ram_we_q <= 1'b0;
            ram_oe_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ram_we_q <= ram_we_d;
            ram_oe_q <= ram_oe_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state and next registered outputs; the RAM strobe for a grant is
    // computed in IDLE so it is registered together with entry into ACCESS.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ram_we_d = 1'b0;
        ram_oe_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata_d  = rdata_q;
        grant    = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_d  = '0;
                wdata_d = '0;
                if (req0 || req1) begin
                    // On a tie the port that was not served last wins.
                    grant    = (req0 && req1) ? ~last_q : req1;
                    owner_d  = grant;
                    we_d     = grant ? we1 : we0;
                    addr_d   = grant ? addr1 : addr0;
                    wdata_d  = grant ? wdata1 : wdata0;
                    ram_we_d = we_d;
                    ram_oe_d = ~we_d;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // RAM read data arrives one clock after the strobe.
                if (!we_q) begin
                    rdata_d = ram_rdata;
                end
                addr_d  = '0;
                wdata_d = '0;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                state_d = S_ACK;
            end
            default: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef RAM_ARBITER_HALT_EN
    logic halt_q;

    // Freeze request registered with entry into ACCESS for port-1 grants,
    // cleared on the ACK -> IDLE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= busy_d && owner_d;
        end
    end

    assign halt = halt_q;
`else
    assign halt = 1'b0;
`endif

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized traffic from
// both ports, checked by a transaction-level reference model and scoreboard.
module tb_ram_arbiter;

`ifdef RAM_ARBITER_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       ack0, ack1, owner, busy, ram_we, ram_oe, halt;
    logic [7:0] rdata, ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .owner(owner), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
        .halt(halt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- RAM model (synchronous read) ----------------
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_oe) ram_rdata <= ram[ram_addr];
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Each granted access occupies a 4-cycle slot; the model keeps the
    // memory image in grant order and predicts read data from it.
    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] ref_mem [256];
    int         m_cnt = 0;
    int         m_owner = 0;
    int         m_last = 1;
    logic [7:0] m_rdata = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   = 0;
            m_last  = 1;
            m_rdata = '0;
            exp_q.delete();
        end else if (m_cnt != 0) begin
            m_cnt--;
        end else if (req0 || req1) begin
            txn_t t;
            t.port  = (req0 && req1) ? (1 - m_last) : (req1 ? 1 : 0);
            t.we    = t.port ? we1 : we0;
            t.addr  = t.port ? addr1 : addr0;
            t.wdata = t.port ? wdata1 : wdata0;
            if (t.we) begin
                ref_mem[t.addr] = t.wdata;
            end else begin
                m_rdata = ref_mem[t.addr];
            end
            t.rdata = m_rdata;
            exp_q.push_back(t);
            m_last  = t.port;
            m_owner = t.port;
            m_cnt   = 3;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int         ack_port_q[$];
    int         ack_cyc_q[$];
    logic [7:0] ack_rdata_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("halt", 32'(halt), 32'(HALT_EN && m_cnt != 0 && m_owner == 1));
            chk("ack0", 32'(ack0), 32'(m_cnt == 1 && m_owner == 0));
            chk("ack1", 32'(ack1), 32'(m_cnt == 1 && m_owner == 1));
            if (ack0 || ack1) begin
                ack_port_q.push_back(ack1 ? 1 : 0);
                ack_cyc_q.push_back(cyc);
                ack_rdata_q.push_back(rdata);
            end
            if (m_cnt != 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'(0), 32'(1));
                end else begin
                    txn_t e;
                    e = exp_q[0];
                    chk("owner", 32'(owner), 32'(e.port));
                    chk("ram_we", 32'(ram_we), 32'(m_cnt == 3 && e.we));
                    chk("ram_oe", 32'(ram_oe), 32'(m_cnt == 3 && !e.we));
                    chk("ram_addr", 32'(ram_addr), (m_cnt == 1) ? 32'(0) : 32'(e.addr));
                    chk("ram_wdata", 32'(ram_wdata), (m_cnt == 1) ? 32'(0) : 32'(e.wdata));
                    if (m_cnt == 1) begin
                        chk("rdata", 32'(rdata), 32'(e.rdata));
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_pins", {ram_addr, ram_wdata, 6'd0, ram_we, ram_oe, 8'd0},
                    32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int p, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    // One transaction; with hold=1 req stays high after ack (back-to-back).
    task automatic txn(input int p, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input bit hold);
        int t;
        @(negedge clk);
        drive(p, 1'b1, w, a, d);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack_of(p) == 1'b0 && t < 40);
        chk("ack_seen", 32'(ack_of(p)), 32'(1));
        if (!hold) begin
            @(negedge clk);
            drive(p, 1'b0, w, a, d);
        end
    endtask

    task automatic run_port(input int p, input int n, input int hold_pct);
        for (int k = 0; k < n; k++) begin
            bit hold;
            hold = ($urandom_range(99, 0) < hold_pct);
            txn(p, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), hold);
            if (!hold) repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int t;
        t = 0;
        while (!(ram_we || ram_oe) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(ram_we || ram_oe), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hc;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {rdata, ram_addr, ram_wdata, 1'b0, ack0, ack1, owner, busy, ram_we, ram_oe, halt},
            32'(0));
        reset = 1'b0;

        // Port 0 writes 0x5A to 0x10, then port 1 reads it back.
        txn(0, 1'b1, 8'h10, 8'h5A, 1'b0);
        chk("ram_written", 32'(ram[8'h10]), 32'h5A);
        txn(1, 1'b0, 8'h10, 8'h00, 1'b0);
        chk("p1_read_port", 32'(ack_port_q[$]), 32'(1));
        chk("p1_read_data", 32'(ack_rdata_q[$]), 32'h5A);

        // Port 1 write: halt covers ACCESS, WAIT and ACK only with the macro.
        hc = 0;
        fork
            txn(1, 1'b1, 8'h44, 8'hC3, 1'b0);
            repeat (10) begin
                @(negedge clk);
                if (halt) hc++;
            end
        join
        chk("halt_cycles", 32'(hc), HALT_EN ? 32'(3) : 32'(0));

        // Both ports request continuously from reset: strict alternation.
        do_reset();
        ack_port_q.delete();
        ack_cyc_q.delete();
        fork
            run_port(0, 2, 100);
            run_port(1, 2, 100);
        join
        chk("alt_count", 32'(ack_port_q.size()), 32'(4));
        if (ack_port_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("alt_order", 32'(ack_port_q[i]), 32'(i % 2));
                if (i > 0) chk("alt_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'(4));
            end
        end

        // req0 dropped during WAIT: ack still pulses, then the arbiter idles.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h20, 8'h33);
        @(negedge clk);
        wait_strobe("drop_strobe");
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h20, 8'h33);
        @(negedge clk);
        chk("drop_ack0", 32'(ack0), 32'(1));
        repeat (5) @(negedge clk);
        chk("drop_idle", 32'(busy), 32'(0));

        // Reset during WAIT of a port 1 read aborts with no ack.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        wait_strobe("rst_strobe");
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 8'h10, 8'h00);
        #1;
        chk("abort_outputs",
            {rdata, ram_addr, ram_wdata, 1'b0, ack0, ack1, owner, busy, ram_we, ram_oe, halt},
            32'(0));
        @(negedge clk);
        chk("abort_no_ack", 32'({ack0, ack1}), 32'(0));
        reset = 1'b0;
        ack_port_q.delete();
        txn(0, 1'b0, 8'h10, 8'h00, 1'b0);
        chk("post_reset_grant", 32'(ack_port_q.size() > 0 ? ack_port_q[0] : 9), 32'(0));

        // Randomized traffic from both ports.
        fork
            run_port(0, 20, 40);
            run_port(1, 20, 40);
        join
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing the single 8-bit-address RAM between the CPU memory path and a secondary requester: a program loader or DMA-style IO engine. The arbiter sits between both requesters and the RAM's address, write-enable and output-enable pins. It serialises accesses with a fixed 4-cycle transaction FSM and round-robin fairness. When configured, it raises a halt request that freezes the CPU clocks while the secondary port owns the RAM.

## Interface
Parameters:
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port 0 (CPU) access request; level, held until `ack0`.
- `we0`  in  1  port 0: 1 = write, 0 = read.
- `addr0`  in  ADDR_W  port 0 address.
- `wdata0`  in  DATA_W  port 0 write data.
- `ack0`  out  1  port 0 one-cycle completion pulse.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`: the same set of signals for port 1 (loader).
- `rdata`  out  DATA_W  read data; shared by both ports and valid while the owning port's ack is high.
- `owner`  out  1  port currently granted; meaningful when `busy`=1.
- `busy`  out  1  high from ACCESS through ACK.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write strobe.
- `ram_oe`  out  1  RAM output/read strobe.
- `ram_rdata`  in  DATA_W  RAM synchronous read data; valid one clock after the `ram_oe` cycle.
- `halt`  out  1  CPU clock-freeze request. See Configuration.

## Operation
- The FSM has four states: IDLE → ACCESS → WAIT → ACK → IDLE. There are no other transitions.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both requests are high, grant the port that is not `last` (the round-robin pointer).
  - On grant: latch `we`, `addr` and `wdata` from the granted port into internal registers, set `owner`, and move to ACCESS.
- **ACCESS**
  - Drive `ram_addr` and `ram_wdata` from the latched registers.
  - Assert `ram_we` for a write, or `ram_oe` for a read, for exactly this one cycle.
- **WAIT**
  - Keep `ram_addr` stable.
  - Strobes are low.
  - For a read, capture `ram_rdata` into the `rdata` register at the end of this state.
- **ACK**
  - Pulse `ack` of `owner` for one cycle; the other port's ack stays 0.
  - Update `last` to `owner`, then return to IDLE.
- `rdata` holds its value until the next read completes. Writes do not change `rdata`.
- Requesters change `addr`, `we` and `wdata` only while their `req` is low or in the cycle after their `ack`. Inputs are sampled only in IDLE.
- If `req` is dropped mid-transaction, the transaction still completes and `ack` still pulses.
- A request still high in the cycle after its `ack` is treated as a new request.
- `ram_addr` and `ram_wdata` read 0 outside ACCESS and WAIT.

## Timing
- Reset values:
  - state IDLE, `last`=1 (so port 0 wins the first tie).
  - `owner`=0, `busy`=0, `ack0`=`ack1`=0.
  - `ram_we`=`ram_oe`=0, `ram_addr`=`ram_wdata`=0.
  - `rdata`=0, `halt`=0.
- Reset asserted mid-transaction aborts it immediately, with no ack. A RAM write whose strobe was already sampled is not undone.
- Latency: with `req` high before edge E0 in IDLE:
  - ACCESS in cycle E0–E1;
  - WAIT in E1–E2;
  - ACK (and valid `rdata` for reads) in E2–E3;
  - IDLE after E3.
- Throughput: one access per 4 cycles when requests are back-to-back on the same port.
- When both ports request continuously, they alternate strictly: 0,1,0,1,… starting from port 0 after reset.
- All outputs are registered. There are no combinational paths from `req`/`addr` to RAM pins.

## Configuration
- Macro: `RAM_ARBITER_HALT_EN`.
- Defined:
  - `halt` goes high in the cycle after the IDLE→ACCESS edge that grants port 1, i.e. it is registered together with entry into ACCESS.
  - `halt` stays high through ACK and clears on the ACK→IDLE edge.
  - If port 1 is re-granted, `halt` drops for the single IDLE cycle.
  - Port 0 transactions never assert `halt`.
- Undefined: `halt` is constant 0 and its logic is not compiled. Arbitration and timing are identical in both builds.

## Test plan
- Reset, then port 0 writes 0x5A to 0x10 → `ram_we`=1 for one cycle with `ram_addr`=0x10 and `ram_wdata`=0x5A; `ack0` pulses 3 cycles after the grant edge; `ack1`=0.
- Port 1 reads 0x10, with the RAM model returning 0x5A → `ram_oe` pulses once; `rdata`=0x5A while `ack1`=1; `owner`=1.
- `req0` and `req1` held high continuously from reset for 4 transactions → grant order 0,1,0,1; each ack occurs 4 cycles after the previous one.
- `req0` dropped during WAIT → `ack0` still pulses in ACK; the FSM returns to IDLE and stays there.
- `reset` asserted during WAIT of a port 1 read → all outputs reach reset values immediately; no ack; the next `req0` is granted from IDLE normally.
- With `RAM_ARBITER_HALT_EN` defined, a port 1 write → `halt` high for 3 cycles (ACCESS, WAIT, ACK). Without the macro → `halt` stays 0.
